// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: hazard detection, operand forwarding, stall/flush and halt/drain
// sequencing for a 5-stage pipeline, plus a saturating stall-cycle counter.
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic             d_uses_rs,
  input  logic             d_uses_rt,
  input  logic             d_branch,
  input  logic             d_redirect,
  input  logic [4:0]       e_wa,
  input  logic             e_rf_we,
  input  logic             e_is_load,
  input  logic [4:0]       m_wa,
  input  logic             m_rf_we,
  input  logic             m_is_load,
  input  logic [4:0]       w_wa,
  input  logic             w_rf_we,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  input  logic             resume,
  output logic [4:0]       stall,
  output logic [4:0]       flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic rs_e, rt_e, rs_m, rt_m, rs_w, rt_w, mem_wait, load_use, br_haz;
  always_comb begin
    rs_e = d_rs != 5'd0 && d_rs == e_wa && e_rf_we;
    rt_e = d_rt != 5'd0 && d_rt == e_wa && e_rf_we;
    rs_m = d_rs != 5'd0 && d_rs == m_wa && m_rf_we;
    rt_m = d_rt != 5'd0 && d_rt == m_wa && m_rf_we;
    rs_w = d_rs != 5'd0 && d_rs == w_wa && w_rf_we;
    rt_w = d_rt != 5'd0 && d_rt == w_wa && w_rf_we;
    mem_wait = dmem_req && !dmem_ready;
    load_use = e_is_load && ((d_uses_rs && rs_e) || (d_uses_rt && rt_e));
    br_haz = d_branch && ((d_uses_rs && (rs_e || (rs_m && m_is_load))) ||
                          (d_uses_rt && (rt_e || (rt_m && m_is_load))));
    state_d = state_q;
    cnt_d = cnt_q;
    stall = '0;
    flush = '0;
    halted = 1'b0;
    fwd_a = rs_m ? 2'b10 : rs_w ? 2'b01 : 2'b00;
    fwd_b = rt_m ? 2'b10 : rt_w ? 2'b01 : 2'b00;
    case (state_q)
      RUN: begin
        if (mem_wait) begin
          stall = '1;
          state_d = MEM_WAIT;
        end else begin
          stall = (load_use || br_haz) ? 5'b00011 : 5'b00000;
          flush = (load_use || br_haz) ? 5'b00100 : d_redirect ? 5'b00010 : 5'b00000;
          state_d = halt_req ? DRAIN : RUN;
          cnt_d = halt_req ? DW'(DRAIN_CYCLES - 1) : cnt_q;
        end
      end
      MEM_WAIT: begin
        stall = dmem_ready ? 5'b00000 : 5'b11111;
        state_d = dmem_ready ? RUN : MEM_WAIT;
      end
      DRAIN: begin
        // a pending DMEM access freezes the whole pipe and pauses the drain count
        stall = mem_wait ? 5'b11111 : 5'b00001;
        flush = mem_wait ? 5'b00000 : 5'b00010;
        cnt_d = (mem_wait || cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        state_d = (!mem_wait && cnt_q == '0) ? HALTED : DRAIN;
      end
      default: begin
        stall = '1;
        halted = 1'b1;
        state_d = resume ? RUN : HALTED;
      end
    endcase
    if (!reset) begin
      stall = '0;
      flush = '1;
      fwd_a = '0;
      fwd_b = '0;
      halted = 1'b0;
    end
    stall_cycles_d = (stall[0] && stall_cycles_q != '1) ? stall_cycles_q + 1'b1 : stall_cycles_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
  assign stall_cycles = stall_cycles_q;
endmodule
